// File: rtl/imem_fetch_bank.sv
// Registered 1-cycle instruction fetch bank for the pipelined MIPS core.
// It provides stall/flush control, a program-load write port, fault flags and an optional post-reset clear.
module imem_fetch_bank #(
  parameter int          ADDR_W         = 32,
  parameter int          DEPTH          = 2048,
  parameter logic [31:0] NOP_WORD       = 32'h0000_0000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              memread,
  input  logic [ADDR_W-1:0] address,
  input  logic              stall,
  input  logic              flush,
  output logic [31:0]       readdata,
  output logic              rvalid,
  output logic              fault_align,
  output logic              fault_range,
  output logic              ready,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [31:0]       prog_wdata,
  output logic              dbg_state
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-3:0] DEPTH_W = (ADDR_W-2)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       readdata_q, readdata_d;
  logic              rvalid_q, rvalid_d;
  logic              fault_align_q, fault_align_d;
  logic              fault_range_q, fault_range_d;
  logic              ready_q, ready_d;

  logic [31:0]       mem_q [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_waddr;
  logic [31:0]       mem_wdata;

  logic [ADDR_W-3:0] rd_idx_full, wr_idx_full;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic              rd_in_range, wr_in_range, rd_misaligned;
  logic [31:0]       rd_word;

  // Full-width compare so a PC past the last word faults instead of aliasing.
  assign rd_idx_full   = address[ADDR_W-1:2];
  assign wr_idx_full   = prog_addr[ADDR_W-1:2];
  assign rd_idx        = address[IDX_W+1:2];
  assign wr_idx        = prog_addr[IDX_W+1:2];
  assign rd_in_range   = (rd_idx_full < DEPTH_W);
  assign wr_in_range   = (wr_idx_full < DEPTH_W);
  assign rd_misaligned = (address[1:0] != 2'b00);
  assign rd_word       = rd_in_range ? mem_q[rd_idx] : NOP_WORD;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    readdata_d    = readdata_q;
    rvalid_d      = rvalid_q;
    fault_align_d = fault_align_q;
    fault_range_d = fault_range_q;
    mem_we        = 1'b0;
    mem_waddr     = cnt_q;
    mem_wdata     = NOP_WORD;

    case (state_q)
      S_CLEAR: begin
        mem_we        = 1'b1;
        readdata_d    = NOP_WORD;
        rvalid_d      = 1'b0;
        fault_align_d = 1'b0;
        fault_range_d = 1'b0;
        if (cnt_q == LAST_IDX) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (prog_we && wr_in_range) begin
          mem_we    = 1'b1;
          mem_waddr = wr_idx;
          mem_wdata = prog_wdata;
        end
        if (flush) begin
          readdata_d    = NOP_WORD;
          rvalid_d      = 1'b0;
          fault_align_d = 1'b0;
          fault_range_d = 1'b0;
        end else if (stall) begin
          readdata_d    = readdata_q;
        end else if (memread) begin
          rvalid_d = 1'b1;
          if (rd_misaligned) begin
            readdata_d    = NOP_WORD;
            fault_align_d = 1'b1;
            fault_range_d = 1'b0;
          end else if (!rd_in_range) begin
            readdata_d    = NOP_WORD;
            fault_align_d = 1'b0;
            fault_range_d = 1'b1;
          end else begin
            readdata_d    = rd_word;
            fault_align_d = 1'b0;
            fault_range_d = 1'b0;
          end
        end else begin
          rvalid_d      = 1'b0;
          fault_align_d = 1'b0;
          fault_range_d = 1'b0;
        end
      end
      default: state_d = S_CLEAR;
    endcase

    ready_d = (state_d == S_READY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      cnt_q         <= '0;
      readdata_q    <= NOP_WORD;
      rvalid_q      <= 1'b0;
      fault_align_q <= 1'b0;
      fault_range_q <= 1'b0;
      ready_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      readdata_q    <= readdata_d;
      rvalid_q      <= rvalid_d;
      fault_align_q <= fault_align_d;
      fault_range_q <= fault_range_d;
      ready_q       <= ready_d;
    end
  end

  // Storage has no reset; the read above uses the pre-edge value (read-before-write).
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign readdata    = readdata_q;
  assign rvalid      = rvalid_q;
  assign fault_align = fault_align_q;
  assign fault_range = fault_range_q;
  assign ready       = ready_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_imem_fetch_bank.sv
// Bench for imem_fetch_bank with DEPTH=16: vector table, random write/fetch pairs,
// and hand-written reset sequences including a reset in the middle of the clear.
module tb_imem_fetch_bank;

  localparam int W = 35;

  logic        clk = 1'b0;
  logic        reset;
  logic        memread;
  logic [31:0] address;
  logic        stall;
  logic        flush;
  logic [31:0] readdata;
  logic        rvalid;
  logic        fault_align;
  logic        fault_range;
  logic        ready;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_wdata;
  logic        dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic        memread;
    logic [31:0] addr;
    logic        stall;
    logic        flush;
    logic        prog_we;
    logic [31:0] paddr;
    logic [31:0] pdata;
    logic        exp_rv;
    logic [31:0] exp_rd;
    logic        exp_fa;
    logic        exp_fr;
  } vec_t;

  vec_t vecs[23];

  imem_fetch_bank #(
    .ADDR_W(32),
    .DEPTH(16),
    .NOP_WORD(32'h0000_0000),
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .memread(memread),
    .address(address),
    .stall(stall),
    .flush(flush),
    .readdata(readdata),
    .rvalid(rvalid),
    .fault_align(fault_align),
    .fault_range(fault_range),
    .ready(ready),
    .prog_we(prog_we),
    .prog_addr(prog_addr),
    .prog_wdata(prog_wdata),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic mr, input logic [31:0] a, input logic st, input logic fl,
                              input logic we, input logic [31:0] pa, input logic [31:0] pd,
                              input logic rv, input logic [31:0] rd, input logic fa, input logic fr);
    vec_t v;
    v.memread = mr; v.addr = a; v.stall = st; v.flush = fl;
    v.prog_we = we; v.paddr = pa; v.pdata = pd;
    v.exp_rv = rv; v.exp_rd = rd; v.exp_fa = fa; v.exp_fr = fr;
    return v;
  endfunction

  task automatic idle();
    memread = 1'b0; address = '0; stall = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
  endtask

  // Drive at a negedge, push the expectation, pop and compare at the next negedge.
  task automatic step(input string name, input vec_t v);
    logic [W-1:0] e;
    memread = v.memread; address = v.addr; stall = v.stall; flush = v.flush;
    prog_we = v.prog_we; prog_addr = v.paddr; prog_wdata = v.pdata;
    exp_q.push_back({v.exp_rv, v.exp_rd, v.exp_fa, v.exp_fr});
    @(posedge clk);
    @(negedge clk);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, 64'({rvalid, readdata, fault_align, fault_range}), 64'(e));
    end
  endtask

  // Counts negedges after reset release until ready rises, bounded at 40 cycles.
  task automatic wait_ready(input string name);
    int n = 0;
    while (!ready && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check(name, 64'(n), 64'd16);
  endtask

  initial begin
    logic [31:0] prev_rd;
    logic [31:0] d;
    int unsigned w;

    idle();
    reset = 1'b1;
    #12;
    check("reset_readdata", 64'(readdata), 64'h0);
    check("reset_rvalid", 64'(rvalid), 64'h0);
    check("reset_faults", 64'({fault_align, fault_range}), 64'h0);
    check("reset_ready", 64'(ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_len");
    idle();

    vecs[0]  = mk(1, 32'h20, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    vecs[1]  = mk(0, 32'h0, 0, 0, 1, 32'h8, 32'h00221820, 0, 32'h0, 0, 0);
    vecs[2]  = mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 32'h00221820, 0, 0);
    vecs[3]  = mk(1, 32'hC, 1, 0, 0, 0, 0, 1, 32'h00221820, 0, 0);
    vecs[4]  = mk(1, 32'hC, 1, 0, 0, 0, 0, 1, 32'h00221820, 0, 0);
    vecs[5]  = mk(1, 32'hC, 1, 0, 0, 0, 0, 1, 32'h00221820, 0, 0);
    vecs[6]  = mk(1, 32'h8, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0);
    vecs[7]  = mk(1, 32'h6, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    vecs[8]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1);
    vecs[9]  = mk(1, 32'h42, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0);
    vecs[10] = mk(0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    vecs[11] = mk(0, 32'h0, 0, 0, 1, 32'h3F, 32'hDEADBEEF, 0, 32'h0, 0, 0);
    vecs[12] = mk(1, 32'h3C, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    vecs[13] = mk(0, 32'h0, 0, 0, 1, 32'h40, 32'h11111111, 0, 32'hDEADBEEF, 0, 0);
    vecs[14] = mk(1, 32'h0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0);
    vecs[15] = mk(1, 32'h3C, 1, 0, 1, 32'h3C, 32'h12345678, 1, 32'h0, 0, 0);
    vecs[16] = mk(1, 32'h3C, 0, 0, 0, 0, 0, 1, 32'h12345678, 0, 0);
    vecs[17] = mk(1, 32'h4, 0, 0, 1, 32'h4, 32'hCAFEF00D, 1, 32'h0, 0, 0);
    vecs[18] = mk(1, 32'h4, 0, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    vecs[19] = mk(1, 32'h10, 0, 1, 1, 32'h10, 32'hA5A5A5A5, 0, 32'h0, 0, 0);
    vecs[20] = mk(1, 32'h10, 0, 0, 0, 0, 0, 1, 32'hA5A5A5A5, 0, 0);
    vecs[21] = mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 1, 32'h0, 0, 1);
    vecs[22] = mk(1, 32'h0, 1, 0, 0, 0, 0, 1, 32'h0, 0, 1);

    for (int i = 0; i < 23; i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Random write-then-fetch pairs; readdata holds across the write cycle.
    prev_rd = 32'h0;
    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(0, 15);
      d = $urandom | 32'h1;
      step($sformatf("rnd_wr%0d", i), mk(0, 0, 0, 0, 1, 32'(w << 2), d, 0, prev_rd, 0, 0));
      step($sformatf("rnd_rd%0d", i), mk(1, 32'(w << 2), 0, 0, 0, 0, 0, 1, d, 0, 0));
      prev_rd = d;
    end

    // Async reset while READY with a live fetch result.
    #2 reset = 1'b1;
    #1;
    check("areset_readdata", 64'(readdata), 64'h0);
    check("areset_rvalid", 64'(rvalid), 64'h0);
    check("areset_ready", 64'(ready), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    memread = 1'b1; address = 32'h4;
    prog_we = 1'b1; prog_addr = 32'h4; prog_wdata = 32'hBAD0BAD0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("clear_rvalid_c%0d", i), 64'({rvalid, readdata, ready}), 64'h0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midclear_reset", 64'({rvalid, readdata, ready}), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_ready("clear_restart_len");
    idle();

    step("post_clear_rd4", mk(1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    step("rbw_same_cycle", mk(1, 32'h4, 0, 0, 1, 32'h4, 32'h0BADF00D, 1, 32'h0, 0, 0));
    step("rbw_next_fetch", mk(1, 32'h4, 0, 0, 0, 0, 0, 1, 32'h0BADF00D, 0, 0));
    step("post_clear_rd8", mk(1, 32'h8, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
